// File: rtl/bus_arbiter.sv
// Two-master, single-slave-bus round-robin arbiter (fetch master M0, load/store master M1).
// Optional ack timeout enabled by defining BUS_TIMEOUT_EN (parameter TIMEOUT_CYCLES).
module bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_M0_REQ,
  input  logic [31:0] i_M0_ADDR,
  input  logic [7:0]  i_M0_CE,
  output logic        o_M0_GNT,
  output logic [31:0] o_M0_RDATA,
  input  logic        i_M1_REQ,
  input  logic [31:0] i_M1_ADDR,
  input  logic [31:0] i_M1_WDATA,
  input  logic        i_M1_WE,
  input  logic [1:0]  i_M1_HB,
  input  logic [7:0]  i_M1_CE,
  output logic        o_M1_GNT,
  output logic [31:0] o_M1_RDATA,
  output logic [31:0] o_S_ADDR,
  output logic [31:0] o_S_WDATA,
  output logic        o_S_WE,
  output logic [1:0]  o_S_HB,
  output logic [7:0]  o_S_CE,
  input  logic [31:0] i_S_RDATA,
  input  logic        i_S_ACK
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OWN_M0 = 2'd1,
    OWN_M1 = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        last_owner;
  logic        owner_req;
  logic [7:0]  owner_ce;
  logic        done;
  logic [31:0] done_data;
  logic        timeout_hit;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 256) begin : g_timeout_range
    $error("bus_arbiter: TIMEOUT_CYCLES must be in 1..256");
  end

`ifdef BUS_TIMEOUT_EN
  logic [7:0] tcount;
  assign timeout_hit = (tcount == 8'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    o_S_ADDR  = 32'h0;
    o_S_WDATA = 32'h0;
    o_S_WE    = 1'b0;
    o_S_HB    = 2'b00;
    o_S_CE    = 8'h00;
    owner_req = 1'b0;
    owner_ce  = 8'h00;
    done      = 1'b0;
    done_data = 32'h0;

    case (state)
      IDLE: begin
        if (i_M0_REQ && i_M1_REQ) state_nxt = last_owner ? OWN_M0 : OWN_M1;
        else if (i_M0_REQ)        state_nxt = OWN_M0;
        else if (i_M1_REQ)        state_nxt = OWN_M1;
      end
      OWN_M0: begin
        owner_req = i_M0_REQ;
        owner_ce  = i_M0_CE;
        o_S_ADDR  = i_M0_ADDR;
        o_S_HB    = 2'b10;
      end
      OWN_M1: begin
        owner_req = i_M1_REQ;
        owner_ce  = i_M1_CE;
        o_S_ADDR  = i_M1_ADDR;
        o_S_WDATA = i_M1_WDATA;
        o_S_WE    = i_M1_WE;
        o_S_HB    = i_M1_HB;
      end
      default: state_nxt = IDLE;
    endcase

    // A dropped request aborts silently; an unmapped select completes at once with all-ones.
    if (state != IDLE) begin
      o_S_CE = owner_req ? owner_ce : 8'h00;
      if (!owner_req) begin
        state_nxt = IDLE;
      end else if (owner_ce == 8'h00) begin
        done      = 1'b1;
        done_data = 32'hFFFF_FFFF;
      end else if (i_S_ACK) begin
        done      = 1'b1;
        done_data = i_S_RDATA;
      end else if (timeout_hit) begin
        done      = 1'b1;
        done_data = 32'hFFFF_FFFF;
      end
      if (done) state_nxt = IDLE;
    end

    // Reset in the same cycle as a completion suppresses the grant.
    o_M0_GNT   = done && (state == OWN_M0) && !i_rst;
    o_M1_GNT   = done && (state == OWN_M1) && !i_rst;
    o_M0_RDATA = o_M0_GNT ? done_data : 32'h0;
    o_M1_RDATA = o_M1_GNT ? done_data : 32'h0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      last_owner <= 1'b1;
`ifdef BUS_TIMEOUT_EN
      tcount     <= 8'h00;
`endif
    end else begin
      state <= state_nxt;
      if (state == IDLE && state_nxt != IDLE) last_owner <= (state_nxt == OWN_M1);
`ifdef BUS_TIMEOUT_EN
      if (state == IDLE) tcount <= 8'h00;
      else               tcount <= tcount + 8'h01;
`endif
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboarded bench for bus_arbiter: directed scenarios plus random traffic against a
// transaction-level reference model; define BUS_TIMEOUT_EN to exercise the timeout path.
module tb_bus_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m1_req, m1_we, s_ack;
  logic [31:0] m0_addr, m1_addr, m1_wdata, s_rdata;
  logic [7:0]  m0_ce, m1_ce;
  logic [1:0]  m1_hb;
  logic        m0_gnt, m1_gnt, s_we;
  logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata;
  logic [1:0]  s_hb;
  logic [7:0]  s_ce;

  bus_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_M0_REQ(m0_req), .i_M0_ADDR(m0_addr), .i_M0_CE(m0_ce),
    .o_M0_GNT(m0_gnt), .o_M0_RDATA(m0_rdata),
    .i_M1_REQ(m1_req), .i_M1_ADDR(m1_addr), .i_M1_WDATA(m1_wdata),
    .i_M1_WE(m1_we), .i_M1_HB(m1_hb), .i_M1_CE(m1_ce),
    .o_M1_GNT(m1_gnt), .o_M1_RDATA(m1_rdata),
    .o_S_ADDR(s_addr), .o_S_WDATA(s_wdata), .o_S_WE(s_we), .o_S_HB(s_hb), .o_S_CE(s_ce),
    .i_S_RDATA(s_rdata), .i_S_ACK(s_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        gnt0;
    logic [31:0] rd0;
    logic        gnt1;
    logic [31:0] rd1;
    logic [31:0] saddr;
    logic [31:0] swdata;
    logic        swe;
    logic [1:0]  shb;
    logic [7:0]  sce;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: which master holds the bus (-1 none), which master wins the next tie,
  // and how many owned cycles have already elapsed in the current tenure.
  int   holder = -1;
  int   tie_winner = 0;
  int   waited = 0;
  bit   model_valid = 0;

  task automatic step();
    exp_t        e;
    logic        req[2];
    logic [31:0] addr[2], wd[2];
    logic        we[2];
    logic [1:0]  hb[2];
    logic [7:0]  ce[2];
    int          next_holder;
    bit          finished;
    logic [31:0] data;
    req  = '{m0_req, m1_req};
    addr = '{m0_addr, m1_addr};
    wd   = '{32'h0, m1_wdata};
    we   = '{1'b0, m1_we};
    hb   = '{2'b10, m1_hb};
    ce   = '{m0_ce, m1_ce};
    e = '{gnt0: 1'b0, rd0: 32'h0, gnt1: 1'b0, rd1: 32'h0, saddr: 32'h0, swdata: 32'h0,
          swe: 1'b0, shb: 2'b00, sce: 8'h00};
    next_holder = holder;
    finished = 0;
    data = 32'h0;
    if (holder < 0) begin
      if (req[0] && req[1]) next_holder = tie_winner;
      else if (req[0])      next_holder = 0;
      else if (req[1])      next_holder = 1;
    end else begin
      e.saddr  = addr[holder];
      e.swdata = wd[holder];
      e.swe    = we[holder];
      e.shb    = hb[holder];
      e.sce    = req[holder] ? ce[holder] : 8'h00;
      if (!req[holder]) next_holder = -1;
      else if (ce[holder] == 8'h00) begin finished = 1; data = 32'hFFFF_FFFF; end
      else if (s_ack)               begin finished = 1; data = s_rdata; end
`ifdef BUS_TIMEOUT_EN
      else if (waited == TO - 1)    begin finished = 1; data = 32'hFFFF_FFFF; end
`endif
      if (finished) begin
        next_holder = -1;
        if (!rst) begin
          if (holder == 0) begin e.gnt0 = 1'b1; e.rd0 = data; end
          else             begin e.gnt1 = 1'b1; e.rd1 = data; end
        end
      end
    end
    if (model_valid) q.push_back(e);
    if (rst) begin
      holder = -1; tie_winner = 0; waited = 0; model_valid = 1;
    end else begin
      if (holder < 0 && next_holder >= 0) begin
        waited = 0;
        tie_winner = 1 - next_holder;
      end else if (holder >= 0) begin
        waited++;
      end
      holder = next_holder;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    rst = 1'b0; m0_req = 1'b0; m1_req = 1'b0; m1_we = 1'b0; s_ack = 1'b0;
    m0_addr = 32'h0; m1_addr = 32'h0; m1_wdata = 32'h0; s_rdata = 32'h0;
    m0_ce = 8'h00; m1_ce = 8'h00; m1_hb = 2'b00;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      vectors++;
      chk("m0_gnt",   32'(m0_gnt),   32'(e.gnt0));
      chk("m0_rdata", m0_rdata,      e.rd0);
      chk("m1_gnt",   32'(m1_gnt),   32'(e.gnt1));
      chk("m1_rdata", m1_rdata,      e.rd1);
      chk("s_addr",   s_addr,        e.saddr);
      chk("s_wdata",  s_wdata,       e.swdata);
      chk("s_we",     32'(s_we),     32'(e.swe));
      chk("s_hb",     32'(s_hb),     32'(e.shb));
      chk("s_ce",     32'(s_ce),     32'(e.sce));
    end
  end

  initial begin
    quiet();
    rst = 1'b1;
    #1;
    step();
    step();
    rst = 1'b0;
    repeat (2) step();

    // M1 read from slave 1, ack one cycle after select
    m1_req = 1'b1; m1_addr = 32'h10; m1_ce = 8'h02; m1_hb = 2'b10;
    step();
    s_ack = 1'b1; s_rdata = 32'hCAFE_0001;
    step();
    quiet();
    repeat (2) step();

    // both masters requesting from reset with instant ack: M0, M1, M0 ...
    rst = 1'b1; step(); rst = 1'b0;
    m0_req = 1'b1; m0_addr = 32'h0000_0100; m0_ce = 8'h01;
    m1_req = 1'b1; m1_addr = 32'h0000_0200; m1_ce = 8'h08;
    s_ack = 1'b1; s_rdata = 32'h5555_AAAA;
    repeat (6) step();
    quiet();
    step();

    // M1 byte write to slave 2
    m1_req = 1'b1; m1_we = 1'b1; m1_hb = 2'b00; m1_ce = 8'h04;
    m1_addr = 32'h0000_0044; m1_wdata = 32'h1234_5678;
    repeat (2) step();
    s_ack = 1'b1;
    step();
    s_ack = 1'b0;
    m1_req = 1'b0;
    repeat (2) step();

    // reset while M0 owns the bus and the slave acks in the same cycle
    quiet();
    m0_req = 1'b1; m0_addr = 32'h0000_0300; m0_ce = 8'h10;
    repeat (2) step();
    rst = 1'b1; s_ack = 1'b1; s_rdata = 32'hDEAD_BEEF;
    step();
    quiet();
    repeat (2) step();

    // unmapped M1 access
    m1_req = 1'b1; m1_ce = 8'h00; m1_addr = 32'h0F00_0000;
    repeat (2) step();
    quiet();
    step();

    // no ack for a long stretch: times out only when the feature is built in
    m1_req = 1'b1; m1_ce = 8'h01; m1_addr = 32'h0000_0080;
    repeat (100) step();
    quiet();
    repeat (2) step();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 5) == 0) m0_req = ~m0_req;
      if ($urandom_range(0, 5) == 0) m1_req = ~m1_req;
      m0_addr  = {8'h00, 24'($urandom())};
      m1_addr  = $urandom();
      m1_wdata = $urandom();
      m1_we    = 1'($urandom_range(0, 1));
      m1_hb    = 2'($urandom_range(0, 2));
      m0_ce    = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'(1 << $urandom_range(0, 7));
      m1_ce    = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'(1 << $urandom_range(0, 7));
      s_ack    = ($urandom_range(0, 9) < 3);
      s_rdata  = $urandom();
      step();
    end
    quiet();
    repeat (3) step();

    for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16: number of cycles an owned transfer waits for an ack before it is aborted (used only when BUS_TIMEOUT_EN is defined).
REQ-002 i_clk  in  1  single system clock; all state updates on rising edge.
REQ-003 i_rst  in  1  synchronous, active-high reset.
REQ-004 i_M0_REQ  in  1  fetch master request (read-only master).
REQ-005 i_M0_ADDR  in  32  fetch address, bits 31:24 already stripped to 8'h00.
REQ-006 i_M0_CE  in  8  fetch one-hot slave select.
REQ-007 o_M0_GNT  out  1  fetch completion pulse.
REQ-008 o_M0_RDATA  out  32  fetch read data.
REQ-009 i_M1_REQ  in  1  load/store master request.
REQ-010 i_M1_ADDR  in  32  load/store address.
REQ-011 i_M1_WDATA  in  32  load/store write data.
REQ-012 i_M1_WE  in  1  load/store write enable.
REQ-013 i_M1_HB  in  2  load/store size code (byte/half/word).
REQ-014 i_M1_CE  in  8  load/store one-hot slave select.
REQ-015 o_M1_GNT  out  1  load/store completion pulse.
REQ-016 o_M1_RDATA  out  32  load/store read data.
REQ-017 o_S_ADDR, o_S_WDATA  out  32 each  shared slave address / write data.
REQ-018 o_S_WE  out  1; o_S_HB  out  2; o_S_CE  out  8  shared slave controls.
REQ-019 i_S_RDATA  in  32; i_S_ACK  in  1  OR-ed slave read data / completion.

Function
REQ-020 FSM states IDLE, OWN_M0, OWN_M1; plus 1-bit last_owner register (0 = M0, 1 = M1).
REQ-021 IDLE: one requester -> next state OWN of that master; both -> OWN of the master not equal to last_owner (round-robin); none -> stay.
REQ-022 On entering OWN_x, last_owner SHALL update to x.
REQ-023 In OWN_x, o_S_* SHALL mirror master x inputs combinationally; M0 drives o_S_WE=0, o_S_HB=2'b10, o_S_WDATA=0.
REQ-024 In IDLE, o_S_CE=0, o_S_WE=0, o_S_ADDR=0, o_S_WDATA=0, o_S_HB=0.
REQ-025 In OWN_x with i_S_ACK=1: o_Mx_GNT=1 same cycle, o_Mx_RDATA=i_S_RDATA, next state IDLE.
REQ-026 o_Mx_RDATA SHALL be 0 whenever master x is not the owner; o_Mx_GNT never asserted outside OWN_x.
REQ-027 Latency: request sampled in IDLE at cycle N -> slave driven at N+1 -> earliest GNT at N+1 -> IDLE at N+2; minimum 2 cycles per transfer, one mandatory IDLE cycle between transfers.
REQ-028 i_S_ACK in IDLE SHALL be ignored.
REQ-029 Owner drops REQ before ack: abort, no GNT, next state IDLE; o_S_CE forced 0 that cycle.
REQ-030 Owner with i_Mx_CE=0 (unmapped region) SHALL complete after one cycle with GNT=1 and RDATA=32'hFFFF_FFFF.

Reset
REQ-031 i_rst=1 at a clock edge: state IDLE, last_owner=1 (M0 wins first tie), timeout counter 0; outputs take IDLE values next cycle.
REQ-032 Reset mid-transfer SHALL abort without any GNT pulse.

Configuration
REQ-033 Macro BUS_TIMEOUT_EN defined: an 8-bit counter clears on entering OWN_x, increments each cycle in OWN_x; when it reaches TIMEOUT_CYCLES-1 without ack, GNT pulses with RDATA=32'hFFFF_FFFF and state returns IDLE.
REQ-034 BUS_TIMEOUT_EN undefined: no counter; OWN_x waits for ack indefinitely.

Verification
REQ-035 M1 read, CE=8'h02, ADDR=32'h10, slave acks one cycle after select with 32'hCAFE_0001 -> o_M1_GNT one cycle, o_M1_RDATA=32'hCAFE_0001, o_M0_RDATA=0.
REQ-036 Both REQ held from reset for 6 cycles, instant ack -> owners M0, M1, M0 on alternating transfers, each separated by one IDLE cycle.
REQ-037 M1 write WDATA=32'h1234_5678, HB=2'b00, CE=8'h04 -> o_S_WE=1, o_S_CE=8'h04, o_S_WDATA matches while owned; o_S_CE=0 after ack.
REQ-038 M0 owner, i_rst pulsed before ack -> no o_M0_GNT; next cycle o_S_CE=0.
REQ-039 BUS_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> o_M1_GNT on 4th owned cycle with RDATA=32'hFFFF_FFFF; without macro, no GNT after 100 cycles.
REQ-040 M1 request with CE=0 -> GNT next cycle, RDATA=32'hFFFF_FFFF, no slave select asserted.
